// File: rtl/field_record_stager.sv
// Record staging register with element/bit/field writes and a 2-entry valid/ready commit queue.
// Optional build macro FIELD_STAGER_PARITY_EN appends a stored even-parity MSB to rec_data.
module field_record_stager #(
  parameter int X_W = 3,
  parameter int X_N = 2,
  parameter int Y_W = 2,
  parameter int Y_N = 3,
  localparam int REC_W  = X_N*X_W + Y_N*Y_W + 1,
  localparam int DATA_W = (X_W > Y_W) ? X_W : Y_W,
  localparam int MAX_N  = (X_N > Y_N) ? X_N : Y_N,
  localparam int IDX_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1,
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1,
`ifdef FIELD_STAGER_PARITY_EN
  localparam int OUT_W  = REC_W + 1
`else
  localparam int OUT_W  = REC_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [1:0]        wr_sel,
  input  logic [1:0]        wr_mode,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [BIT_W-1:0]  wr_bit,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit,
  output logic [REC_W-1:0]  live_rec,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [OUT_W-1:0]  rec_data,
  output logic              ovf,
  output logic              idx_err
);

  logic [X_N-1:0][X_W-1:0] x_q, x_d;
  logic [Y_N-1:0][Y_W-1:0] y_q, y_d;
  logic                    z_q, z_d;
  logic [OUT_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    ovf_q, ovf_d, err_q, err_d;
  logic [REC_W-1:0]        snap;
  logic [OUT_W-1:0]        entry;
  logic                    x_idx_ok, y_idx_ok, x_bit_ok, y_bit_ok;
  logic                    pop, push, full;

  // x element 0 sits at the low end of its slice, y element 0 at the high end.
  function automatic logic [REC_W-1:0] pack_rec(input logic [X_N-1:0][X_W-1:0] x,
                                                input logic [Y_N-1:0][Y_W-1:0] y,
                                                input logic z);
    logic [Y_N*Y_W-1:0] yf;
    yf = '0;
    for (int i = 0; i < Y_N; i++) yf[(Y_N-1-i)*Y_W +: Y_W] = y[i];
    return {x, yf, z};
  endfunction

  assign x_idx_ok = 32'(wr_idx) < X_N;
  assign y_idx_ok = 32'(wr_idx) < Y_N;
  assign x_bit_ok = 32'(wr_bit) < X_W;
  assign y_bit_ok = 32'(wr_bit) < Y_W;

  // NOTE: every variable written here gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    z_d   = z_q;
    err_d = err_q;
    if (wr_en) begin
      unique case (wr_sel)
        2'd0: unique case (wr_mode)
          2'd0: if (x_idx_ok) begin
                  for (int i = 0; i < X_N; i++)
                    if (wr_idx == IDX_W'(i)) x_d[i] = wr_data[X_W-1:0];
                end else err_d = 1'b1;
          2'd1: if (x_idx_ok && x_bit_ok) begin
                  for (int i = 0; i < X_N; i++)
                    for (int j = 0; j < X_W; j++)
                      if (wr_idx == IDX_W'(i) && wr_bit == BIT_W'(j)) x_d[i][j] = wr_data[0];
                end else err_d = 1'b1;
          2'd2: x_d = '0;
          2'd3: x_d = '1;
        endcase
        2'd1: unique case (wr_mode)
          2'd0: if (y_idx_ok) begin
                  for (int i = 0; i < Y_N; i++)
                    if (wr_idx == IDX_W'(i)) y_d[i] = wr_data[Y_W-1:0];
                end else err_d = 1'b1;
          2'd1: if (y_idx_ok && y_bit_ok) begin
                  for (int i = 0; i < Y_N; i++)
                    for (int j = 0; j < Y_W; j++)
                      if (wr_idx == IDX_W'(i) && wr_bit == BIT_W'(j)) y_d[i][j] = wr_data[0];
                end else err_d = 1'b1;
          2'd2: y_d = '0;
          2'd3: y_d = '1;
        endcase
        2'd2: unique case (wr_mode)
          2'd0, 2'd1: z_d = wr_data[0];
          2'd2:       z_d = 1'b0;
          2'd3:       z_d = 1'b1;
        endcase
        2'd3: err_d = 1'b1;
      endcase
    end
  end

  // The snapshot is taken from next-state values so a same-cycle write is included.
  assign snap = pack_rec(x_d, y_d, z_d);
`ifdef FIELD_STAGER_PARITY_EN
  assign entry = {^snap, snap};
`else
  assign entry = snap;
`endif

  assign full = (cnt_q == 2'd2);
  assign pop  = (cnt_q != 2'd0) && rec_ready;
  assign push = commit && (!full || pop);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | (commit && full && !pop);
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = entry;
        else               tail_d = entry;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) head_d = entry;
        else begin
          head_d = tail_q;
          tail_d = entry;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values together.
  // NOTE: the staging elements and queue slots are a handful of flops, not a RAM, so all of them are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

  assign live_rec  = pack_rec(x_q, y_q, z_q);
  assign rec_valid = (cnt_q != 2'd0);
  assign rec_data  = head_q;
  assign ovf       = ovf_q;
  assign idx_err   = err_q;

endmodule
